// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the memory-port arbiter and its lane aligner.
// Access-size encodings and arbiter state encoding live here.
package cpu_pkg;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store-side byte enables and lane replication,
// load-side lane extraction with zero extension. Mode 2'b11 behaves as word.
module mem_lane_align
    import cpu_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata
);

    // NOTE: every output gets a default before the case so no latch can be inferred.
    always_comb begin
        be        = 4'hF;
        wdata_rep = wdata;
        rdata     = rword;
        case (mode)
            MODE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata     = {24'h0, rword[{addr_lo, 3'b000} +: 8]};
            end
            MODE_HALF: begin
                be        = addr_lo[1] ? 4'hC : 4'h3;
                wdata_rep = {2{wdata[15:0]}};
                rdata     = addr_lo[1] ? {16'h0, rword[31:16]} : {16'h0, rword[15:0]};
            end
            default: begin
                be        = 4'hF;
                wdata_rep = wdata;
                rdata     = rword;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between IF fetch and MEM load/store,
// issuing one fixed-latency access at a time and driving the pipeline stall.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
)
(
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        ifReq,
    input  logic [31:0] ifAddr,
    output logic [31:0] ifRdata,
    output logic        ifDone,
    input  logic        memReq,
    input  logic        memWe,
    input  logic [31:0] memAddr,
    input  logic [31:0] memWdata,
    input  logic [1:0]  memMode,
    output logic [31:0] memRdata,
    output logic        memDone,
    output logic        stall,
    output logic        mValid,
    output logic        mWe,
    output logic [31:0] mAddr,
    output logic [3:0]  mBe,
    output logic [31:0] mWdata,
    input  logic [31:0] mRdata
);

    localparam int unsigned   CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic          if_served, mem_served;
    logic [31:0]   if_hold, mem_hold;
    logic          if_pend, mem_pend;
    logic          issue_if, issue_mem;
    logic          last_beat;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata, lane_rdata;

    mem_lane_align u_align (
        .mode      (memMode),
        .addr_lo   (memAddr[1:0]),
        .wdata     (memWdata),
        .rword     (mRdata),
        .be        (lane_be),
        .wdata_rep (lane_wdata),
        .rdata     (lane_rdata)
    );

    assign if_pend   = ifReq & ~if_served;
    assign mem_pend  = memReq & ~mem_served;
    assign last_beat = (cnt == CW'(1));

    // A low RSTn masks every strobe in the same cycle, so an access caught by
    // reset in its final beat never reports completion.
    always_comb begin
        state_nxt = state;
        issue_if  = 1'b0;
        issue_mem = 1'b0;
        ifDone    = 1'b0;
        memDone   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (RSTn && mem_pend) begin
                    issue_mem = 1'b1;
                    state_nxt = ST_BUSY_MEM;
                end else if (RSTn && if_pend) begin
                    issue_if  = 1'b1;
                    state_nxt = ST_BUSY_IF;
                end
            end
            ST_BUSY_IF: begin
                if (last_beat) begin
                    ifDone    = RSTn;
                    state_nxt = ST_IDLE;
                end
            end
            ST_BUSY_MEM: begin
                if (last_beat) begin
                    memDone   = RSTn;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mValid = issue_if | issue_mem;
        mWe    = issue_mem & memWe;
        mAddr  = 32'h0;
        mBe    = 4'h0;
        mWdata = 32'h0;
        if (issue_mem) begin
            mAddr  = memAddr & ~32'h3;
            mBe    = memWe ? lane_be : 4'hF;
            mWdata = memWe ? lane_wdata : 32'h0;
        end else if (issue_if) begin
            mAddr  = ifAddr & ~32'h3;
            mBe    = 4'hF;
        end
    end

    assign ifRdata  = !RSTn ? 32'h0 : (ifDone  ? mRdata     : if_hold);
    assign memRdata = !RSTn ? 32'h0 : (memDone ? lane_rdata : mem_hold);
    assign stall    = RSTn & ((ifReq  & ~ifDone  & ~if_served) |
                              (memReq & ~memDone & ~mem_served));

    // NOTE: sequential state uses non-blocking assignments and a synchronous
    // reset sampled on the clock edge; hold registers are reset so outputs read 0.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            if_served  <= 1'b0;
            mem_served <= 1'b0;
            if_hold    <= 32'h0;
            mem_hold   <= 32'h0;
        end else begin
            state <= state_nxt;
            if (issue_if || issue_mem) begin
                cnt <= LAT_LOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (ifDone) begin
                if_hold <= mRdata;
            end
            if (memDone) begin
                mem_hold <= lane_rdata;
            end
            // Pipeline advance retires both requesters; otherwise remember who finished.
            if (!stall) begin
                if_served  <= 1'b0;
                mem_served <= 1'b0;
            end else begin
                if (ifDone) begin
                    if_served <= 1'b1;
                end
                if (memDone) begin
                    mem_served <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: plays pipeline and fixed-latency memory around the
// arbiter and compares against a word-array model of memory and timing rules.
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    localparam int L = 2;

    logic        CLK, RSTn;
    logic        ifReq, memReq, memWe;
    logic [31:0] ifAddr, memAddr, memWdata;
    logic [1:0]  memMode;
    logic [31:0] ifRdata, memRdata, mAddr, mWdata, mRdata;
    logic        ifDone, memDone, stall, mValid, mWe;
    logic [3:0]  mBe;

    mem_port_arbiter #(.MEM_LAT(L)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifDone(ifDone),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memMode(memMode), .memRdata(memRdata), .memDone(memDone),
        .stall(stall), .mValid(mValid), .mWe(mWe), .mAddr(mAddr), .mBe(mBe),
        .mWdata(mWdata), .mRdata(mRdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          off;
    } iss_t;

    logic [31:0] env_mem   [64];
    logic [31:0] model_mem [64];
    rsp_t        rsp_q[$];
    iss_t        iss_q[$];
    int          cyc = 0;
    int          we_pulses = 0;

    int          adv_off, if_done_off, mem_done_off, if_done_cnt, mem_done_cnt;
    logic [31:0] if_done_data, mem_done_data, adv_if_data, adv_mem_data;

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hBEEF1234;
        return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] exp_extract(logic [31:0] w, logic [1:0] a, logic [1:0] mo);
        if (mo == MODE_BYTE) return (w >> (8 * int'(a))) & 32'hFF;
        if (mo == MODE_HALF) return (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
        return w;
    endfunction

    function automatic logic [31:0] exp_merge(logic [31:0] old, logic [31:0] d, logic [1:0] a, logic [1:0] mo);
        int          sh;
        logic [31:0] mask;
        if (mo == MODE_BYTE) begin
            sh   = 8 * int'(a);
            mask = 32'hFF << sh;
            return (old & ~mask) | ((d & 32'hFF) << sh);
        end
        if (mo == MODE_HALF) begin
            sh   = a[1] ? 16 : 0;
            mask = 32'hFFFF << sh;
            return (old & ~mask) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    // Memory environment: writes at issue, read word returned MEM_LAT cycles later,
    // random garbage on mRdata in every other cycle.
    initial begin
        rsp_t r;
        for (int i = 0; i < 64; i++) env_mem[i] = init_word(i);
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            while (rsp_q.size() > 0 && rsp_q[0].due < cyc) rsp_q.delete(0);
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                r = rsp_q[0];
                rsp_q.delete(0);
                mRdata = r.data;
            end else begin
                mRdata = $urandom;
            end
            @(negedge CLK);
            if (mValid) begin
                if (mWe) begin
                    we_pulses++;
                    for (int b = 0; b < 4; b++)
                        if (mBe[b]) env_mem[mAddr[7:2]][8*b +: 8] = mWdata[8*b +: 8];
                end else begin
                    r.due  = cyc + L;
                    r.data = env_mem[mAddr[7:2]];
                    rsp_q.push_back(r);
                end
            end
        end
    end

    task automatic do_step(input logic ir, input logic [31:0] ia, input logic mr, input logic we,
                           input logic [31:0] ma, input logic [31:0] md, input logic [1:0] mo);
        int   off;
        iss_t e;
        @(posedge CLK);
        #1;
        ifReq = ir; ifAddr = ia; memReq = mr; memWe = we;
        memAddr = ma; memWdata = md; memMode = mo;
        iss_q.delete();
        if_done_cnt = 0; mem_done_cnt = 0;
        if_done_off = -1; mem_done_off = -1; adv_off = -1;
        off = 0;
        while (off <= 60) begin
            @(negedge CLK);
            if (mValid) begin
                e.addr = mAddr; e.be = mBe; e.wdata = mWdata; e.we = mWe; e.off = off;
                iss_q.push_back(e);
            end
            if (ifDone)  begin if_done_cnt++;  if_done_off = off;  if_done_data = ifRdata;   end
            if (memDone) begin mem_done_cnt++; mem_done_off = off; mem_done_data = memRdata; end
            if (!stall) begin
                adv_off = off; adv_if_data = ifRdata; adv_mem_data = memRdata;
                break;
            end
            off++;
        end
        n_checks++;
        if (adv_off < 0) begin
            n_errors++;
            $display("FAIL step_timeout: stall still high after %0d cycles, required release", off);
        end
    endtask

    task automatic test_reset();
        int w;
        RSTn = 1'b0; ifReq = 1'b1; ifAddr = 32'h104;
        memReq = 1'b0; memWe = 1'b0; memAddr = 32'h0; memWdata = 32'h0; memMode = MODE_WORD;
        repeat (2) begin
            @(negedge CLK);
            n_checks++;
            if ({ifRdata, ifDone, memRdata, memDone, stall, mValid, mWe, mAddr, mBe, mWdata} !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs: got mValid=%b stall=%b mAddr=%h, required all zero", mValid, stall, mAddr);
            end
        end
        @(posedge CLK);
        #1 RSTn = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (mValid !== 1'b1 || mAddr !== 32'h104) begin
            n_errors++;
            $display("FAIL reset_release_issue: got mValid=%b mAddr=%h, required 1 / 00000104", mValid, mAddr);
        end
        w = 0;
        while (stall === 1'b1 && w < 20) begin
            @(negedge CLK);
            w++;
        end
        n_checks++;
        if (w != L || ifRdata !== model_mem[1]) begin
            n_errors++;
            $display("FAIL reset_first_fetch: got %0d cycles data %h, required %0d / %h", w, ifRdata, L, model_mem[1]);
        end
    endtask

    task automatic test_if_only();
        do_step(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, MODE_WORD);
        n_checks++;
        if (iss_q.size() != 1 || iss_q[0].addr !== 32'h104 || iss_q[0].be !== 4'hF || iss_q[0].we !== 1'b0) begin
            n_errors++;
            $display("FAIL if_issue: got %0d issues, required one word read at 00000104", iss_q.size());
        end
        n_checks++;
        if (if_done_off != L || adv_off != L) begin
            n_errors++;
            $display("FAIL if_timing: got done@%0d advance@%0d, required %0d / %0d", if_done_off, adv_off, L, L);
        end
        n_checks++;
        if (if_done_data !== model_mem[1]) begin
            n_errors++;
            $display("FAIL if_data: got %h, required %h", if_done_data, model_mem[1]);
        end
    endtask

    task automatic test_both_store_byte();
        int wb;
        wb = we_pulses;
        model_mem[0] = exp_merge(model_mem[0], 32'hAB, 2'd3, MODE_BYTE);
        do_step(1'b1, 32'h040, 1'b1, 1'b1, 32'h203, 32'h0000_00AB, MODE_BYTE);
        n_checks++;
        if (iss_q.size() != 2) begin
            n_errors++;
            $display("FAIL both_issue_count: got %0d, required 2", iss_q.size());
        end else begin
            n_checks++;
            if (iss_q[0].we !== 1'b1 || iss_q[0].be !== 4'h8 || iss_q[0].wdata !== 32'hABABABAB ||
                iss_q[0].addr !== 32'h200 || iss_q[0].off != 0) begin
                n_errors++;
                $display("FAIL both_store_issue: got we=%b be=%h wd=%h a=%h, required 1/8/abababab/00000200",
                         iss_q[0].we, iss_q[0].be, iss_q[0].wdata, iss_q[0].addr);
            end
            n_checks++;
            if (iss_q[1].we !== 1'b0 || iss_q[1].addr !== 32'h040 || iss_q[1].off != L + 1) begin
                n_errors++;
                $display("FAIL both_fetch_issue: got we=%b a=%h @%0d, required 0/00000040 @%0d",
                         iss_q[1].we, iss_q[1].addr, iss_q[1].off, L + 1);
            end
        end
        n_checks++;
        if (mem_done_off != L || if_done_off != 2 * L + 1 || adv_off != 2 * L + 1 ||
            mem_done_cnt != 1 || if_done_cnt != 1) begin
            n_errors++;
            $display("FAIL both_timing: got memDone@%0d ifDone@%0d adv@%0d, required %0d/%0d/%0d",
                     mem_done_off, if_done_off, adv_off, L, 2 * L + 1, 2 * L + 1);
        end
        n_checks++;
        if (we_pulses - wb != 1) begin
            n_errors++;
            $display("FAIL both_write_once: got %0d writes, required 1", we_pulses - wb);
        end
        n_checks++;
        if (adv_if_data !== model_mem[16]) begin
            n_errors++;
            $display("FAIL both_fetch_data: got %h, required %h", adv_if_data, model_mem[16]);
        end
        do_step(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, MODE_WORD);
        n_checks++;
        if (adv_mem_data !== model_mem[0]) begin
            n_errors++;
            $display("FAIL byte_store_readback: got %h, required %h", adv_mem_data, model_mem[0]);
        end
    endtask

    task automatic test_half_load();
        do_step(1'b1, 32'h008, 1'b1, 1'b0, 32'h012, 32'h0, MODE_HALF);
        n_checks++;
        if (iss_q.size() != 2 || iss_q[0].be !== 4'hF || iss_q[0].addr !== 32'h010) begin
            n_errors++;
            $display("FAIL half_issue: got %0d issues, required load at 00000010 with be=f first", iss_q.size());
        end
        n_checks++;
        if (mem_done_data !== 32'h0000BEEF) begin
            n_errors++;
            $display("FAIL half_data: got %h, required 0000beef", mem_done_data);
        end
        n_checks++;
        if (adv_mem_data !== 32'h0000BEEF || adv_off != 2 * L + 1) begin
            n_errors++;
            $display("FAIL half_hold: got %h @%0d, required 0000beef @%0d", adv_mem_data, adv_off, 2 * L + 1);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(posedge CLK);
        #1;
        ifReq = 1'b0; memReq = 1'b1; memWe = 1'b0; memAddr = 32'h024; memMode = MODE_WORD;
        @(negedge CLK);
        n_checks++;
        if (mValid !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_issue: got mValid=%b, required 1", mValid);
        end
        repeat (L) @(posedge CLK);
        #1;
        RSTn = 1'b0; memReq = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (memDone !== 1'b0 || stall !== 1'b0 || mValid !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_suppress: got memDone=%b stall=%b mValid=%b, required 0/0/0", memDone, stall, mValid);
        end
        @(posedge CLK);
        #1 RSTn = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            n_checks++;
            if (memRdata !== 32'h0 || memDone !== 1'b0 || mValid !== 1'b0) begin
                n_errors++;
                $display("FAIL midrst_after: got memRdata=%h memDone=%b mValid=%b, required 0/0/0", memRdata, memDone, mValid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          wb;
        logic [31:0] d;
        d = $urandom;
        model_mem[12] = d;
        wb = we_pulses;
        do_step(1'b0, 32'h0, 1'b1, 1'b1, 32'h030, d, MODE_WORD);
        n_checks++;
        if (we_pulses - wb != 1 || adv_off != L) begin
            n_errors++;
            $display("FAIL b2b_store: got %0d writes adv@%0d, required 1 / %0d", we_pulses - wb, adv_off, L);
        end
        do_step(1'b0, 32'h0, 1'b1, 1'b0, 32'h030, 32'h0, MODE_WORD);
        n_checks++;
        if (iss_q.size() != 1 || iss_q[0].off != 0 || adv_mem_data !== d) begin
            n_errors++;
            $display("FAIL b2b_load: got %0d issues data %h, required immediate issue / %h", iss_q.size(), adv_mem_data, d);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic        ir, mr, we;
            logic [31:0] ia, ma, md, mem_exp, if_exp;
            logic [1:0]  mo;
            int          n, exp_adv, wb;
            ir = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 3) != 0);
            we = $urandom_range(0, 1) == 1;
            ia = $urandom_range(0, 255);
            ma = $urandom_range(0, 255);
            md = $urandom;
            mo = 2'($urandom_range(0, 3));
            if (mr && we) model_mem[ma[7:2]] = exp_merge(model_mem[ma[7:2]], md, ma[1:0], mo);
            mem_exp = exp_extract(model_mem[ma[7:2]], ma[1:0], mo);
            if_exp  = model_mem[ia[7:2]];
            n       = int'(ir) + int'(mr);
            exp_adv = (n == 0) ? 0 : (n == 1) ? L : 2 * L + 1;
            wb      = we_pulses;
            do_step(ir, ia, mr, we, ma, md, mo);
            n_checks++;
            if (adv_off != exp_adv || iss_q.size() != n) begin
                n_errors++;
                $display("FAIL rnd%0d_timing: got adv@%0d issues=%0d, required %0d / %0d", k, adv_off, iss_q.size(), exp_adv, n);
            end
            n_checks++;
            if (we_pulses - wb != int'(mr && we)) begin
                n_errors++;
                $display("FAIL rnd%0d_writes: got %0d, required %0d", k, we_pulses - wb, int'(mr && we));
            end
            if (mr && !we) begin
                n_checks++;
                if (adv_mem_data !== mem_exp) begin
                    n_errors++;
                    $display("FAIL rnd%0d_load: got %h, required %h", k, adv_mem_data, mem_exp);
                end
            end
            if (ir) begin
                n_checks++;
                if (adv_if_data !== if_exp) begin
                    n_errors++;
                    $display("FAIL rnd%0d_fetch: got %h, required %h", k, adv_if_data, if_exp);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
        test_reset();
        test_if_only();
        test_both_store_byte();
        test_half_load();
        test_reset_mid_busy();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
